// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared constants and types for the instruction-fetch AXI read bridge.
package inst_axi_rd_bridge_pkg;

  localparam logic [2:0] AXI_SIZE_WORD    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
  localparam logic [3:0] ARCACHE_CACHED   = 4'b1111;
  localparam logic [3:0] ARCACHE_UNCACHED = 4'b0000;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_e;

  function automatic logic [3:0] arcache_sel(input logic cached);
    return cached ? ARCACHE_CACHED : ARCACHE_UNCACHED;
  endfunction

endpackage

// File: rtl/inst_axi_rd_bridge.sv
// Read-only bridge from the fetch stage's sram-like port to an AXI read channel.
// Single ARID, single-beat reads, in-order responses, up to MAX_OUTST in flight.
// Optional performance counters are built when INST_BRIDGE_PERF_EN is defined;
// otherwise the perf outputs are tied to zero.
//
// AR FSM states:
//   state   | meaning
//   AR_IDLE | no address pending on the AR channel
//   AR_SEND | arvalid held with latched address until arready
module inst_axi_rd_bridge
  import inst_axi_rd_bridge_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [3:0]  AXI_ID    = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  input  logic        i_cached_or_not,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        bus_err,
  output logic [31:0] perf_req_cnt,
  output logic [31:0] perf_wait_cnt
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);

  ar_state_e   ar_state;
  ar_state_e   ar_state_nxt;
  logic [31:0] araddr_q;
  logic [3:0]  arcache_q;
  logic [OW-1:0] outst;
  logic        addr_ok;
  logic        r_beat;
  logic        data_ok_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  // Write-side fields, size, RID and RLAST carry no information for single-beat reads.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_size, inst_sram_wstrb,
                           inst_sram_wdata, rid, rlast};

  assign addr_ok = inst_sram_req & (ar_state == AR_IDLE) & (outst < OUTST_MAX) & ~reset;
  assign rready  = (outst != '0);
  assign r_beat  = rvalid & rready;

  assign inst_sram_addr_ok = addr_ok;
  assign inst_sram_data_ok = data_ok_q;
  assign inst_sram_rdata   = rdata_q;
  assign bus_err           = data_ok_q & (|rresp_q);

  assign arid    = AXI_ID;
  assign araddr  = araddr_q;
  assign arlen   = 8'd0;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = arcache_q;
  assign arprot  = 3'b000;

  // AR state register
  always_ff @(posedge clk) begin
    if (reset) ar_state <= AR_IDLE;
    else       ar_state <= ar_state_nxt;
  end

  // AR next-state: leave idle on accept, return once the slave takes the address
  always_comb begin
    ar_state_nxt = ar_state;
    case (ar_state)
      AR_IDLE: if (addr_ok) ar_state_nxt = AR_SEND;
      AR_SEND: if (arready) ar_state_nxt = AR_IDLE;
      default: ar_state_nxt = AR_IDLE;
    endcase
  end

  // AR outputs: valid exactly while an address is waiting for the slave
  always_comb begin
    arvalid = (ar_state == AR_SEND);
  end

  // Address/cache attribute latch; only loads in idle so fields stay stable under arvalid
  always_ff @(posedge clk) begin
    if (reset) begin
      araddr_q  <= 32'd0;
      arcache_q <= ARCACHE_UNCACHED;
    end else if (addr_ok) begin
      araddr_q  <= inst_sram_addr;
      arcache_q <= arcache_sel(i_cached_or_not);
    end
  end

  // Outstanding counter: accepted but not yet answered on R
  always_ff @(posedge clk) begin
    if (reset) begin
      outst <= '0;
    end else begin
      case ({addr_ok, r_beat})
        2'b10:   outst <= outst + 1'b1;
        2'b01:   outst <= outst - 1'b1;
        default: outst <= outst;
      endcase
    end
  end

  // R capture: one data_ok pulse the cycle after each accepted beat
  always_ff @(posedge clk) begin
    if (reset) begin
      data_ok_q <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'b00;
    end else begin
      data_ok_q <= r_beat;
      if (r_beat) begin
        rdata_q <= rdata;
        rresp_q <= rresp;
      end
    end
  end

`ifdef INST_BRIDGE_PERF_EN
  logic [31:0] req_cnt_q;
  logic [31:0] wait_cnt_q;

  // Free-running wrap-around counters of accepts and stalled-with-work cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      req_cnt_q  <= 32'd0;
      wait_cnt_q <= 32'd0;
    end else begin
      if (addr_ok)                          req_cnt_q  <= req_cnt_q + 32'd1;
      if ((outst != '0) && !data_ok_q)      wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign perf_req_cnt  = req_cnt_q;
  assign perf_wait_cnt = wait_cnt_q;
`else
  assign perf_req_cnt  = 32'b0;
  assign perf_wait_cnt = 32'b0;
`endif

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Self-checking bench for inst_axi_rd_bridge: random AXI slave, scoreboard, reference model.
module tb_inst_axi_rd_bridge;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        i_cached_or_not;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        bus_err;
  logic [31:0] perf_req_cnt;
  logic [31:0] perf_wait_cnt;

  inst_axi_rd_bridge #(.MAX_OUTST(MAX), .AXI_ID(4'd0)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .i_cached_or_not(i_cached_or_not),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready), .bus_err(bus_err),
    .perf_req_cnt(perf_req_cnt), .perf_wait_cnt(perf_wait_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {logic [31:0] data; logic err; int acc; bit lat;} exp_t;
  typedef struct {logic [31:0] addr; int rdy;} rd_t;
  exp_t sb[$];
  rd_t  sq[$];

  // reference model state
  int          m_outst;
  bit          m_ar_pend;
  logic [31:0] m_ar_addr;
  logic [3:0]  m_ar_cache;
  bit          m_prev_beat;
  int          m_req_cnt;
  int          m_wait_cnt;
  bit          last_ok;

  // slave / stimulus knobs
  int ar_prob = 100;
  int r_dmin  = 1;
  int r_dmax  = 1;
  bit lat_chk = 1'b0;

  // memory contents and error map seen by the AXI slave
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h1fc0_0000) return 32'h3c08_bfaf;
    if (a == 32'he000_0000) return 32'hdead_beef;
    return a ^ {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    if (a[31:28] == 4'he) return 2'b10;
    if (a[31:28] == 4'hd) return 2'b11;
    return 2'b00;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: pops the scoreboard on every data_ok pulse
  always @(negedge clk) begin
    if (!reset) begin
      if (inst_sram_data_ok) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL data_ok_unexpected actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rdata", inst_sram_rdata, e.data);
          chk("bus_err", {31'd0, bus_err}, {31'd0, e.err});
          if (e.lat) chk("latency", cyc - e.acc, 3);
        end
      end else if (bus_err) begin
        total++; bad++;
        $display("FAIL bus_err_no_data_ok actual=1 required=0 (cycle %0d)", cyc);
      end
    end
  end

  task automatic clear_model();
    sb.delete(); sq.delete();
    m_outst = 0; m_ar_pend = 0; m_ar_addr = 0; m_ar_cache = 0;
    m_prev_beat = 0; m_req_cnt = 0; m_wait_cnt = 0;
  endtask

  // one bus cycle: drive, sample at negedge, advance the model
  task automatic step(input bit want_req, input logic [31:0] a, input logic c);
    bit exp_ok, beat;
    @(posedge clk); #1;
    inst_sram_req   = want_req;
    inst_sram_addr  = a;
    i_cached_or_not = c;
    arready = ($urandom_range(99) < ar_prob);
    rlast   = 1'b1;
    if (sq.size() > 0 && cyc >= sq[0].rdy) begin
      rvalid = 1'b1; rdata = mem(sq[0].addr); rresp = resp_of(sq[0].addr);
    end else begin
      rvalid = 1'b0; rdata = $urandom; rresp = 2'($urandom);
    end
    @(negedge clk);
    exp_ok = want_req && !m_ar_pend && (m_outst < MAX);
    beat   = rvalid && (m_outst != 0);
    chk("addr_ok", {31'd0, inst_sram_addr_ok}, {31'd0, exp_ok});
    chk("arvalid", {31'd0, arvalid}, {31'd0, m_ar_pend});
    chk("rready", {31'd0, rready}, {31'd0, (m_outst != 0)});
    if (m_ar_pend) begin
      chk("araddr", araddr, m_ar_addr);
      chk("arcache", {28'd0, arcache}, {28'd0, m_ar_cache});
    end
    if (m_outst != 0 && !m_prev_beat) m_wait_cnt++;
    if (m_ar_pend && arready) begin
      rd_t r;
      r.addr = m_ar_addr;
      r.rdy  = cyc + $urandom_range(r_dmax, r_dmin);
      sq.push_back(r);
      m_ar_pend = 0;
    end
    if (beat) void'(sq.pop_front());
    if (exp_ok) begin
      exp_t e;
      e.data = mem(a); e.err = (resp_of(a) != 2'b00); e.acc = cyc; e.lat = lat_chk;
      sb.push_back(e);
      m_ar_pend = 1; m_ar_addr = a; m_ar_cache = c ? 4'b1111 : 4'b0000;
      m_req_cnt++;
    end
    m_outst     = m_outst + (exp_ok ? 1 : 0) - (beat ? 1 : 0);
    m_prev_beat = beat;
    last_ok     = exp_ok;
  endtask

  task automatic issue(input logic [31:0] a, input logic c);
    int n = 0;
    last_ok = 0;
    while (!last_ok && n < 200) begin step(1'b1, a, c); n++; end
    if (!last_ok) begin
      total++; bad++;
      $display("FAIL issue_timeout actual=no_accept required=accept addr=%h", a);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || m_ar_pend || m_outst != 0) && n < 300) begin
      step(1'b0, 32'd0, 1'b0); n++;
    end
    step(1'b0, 32'd0, 1'b0);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", sb.size());
    end
  endtask

  task automatic check_perf(input string nm);
    @(posedge clk); #1;
`ifdef INST_BRIDGE_PERF_EN
    chk({nm, "_req"}, perf_req_cnt, 32'(m_req_cnt));
    chk({nm, "_wait"}, perf_wait_cnt, 32'(m_wait_cnt));
`else
    chk({nm, "_req"}, perf_req_cnt, 32'd0);
    chk({nm, "_wait"}, perf_wait_cnt, 32'd0);
`endif
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; inst_sram_req = 1'b1; rvalid = 1'b0; arready = 1'b1;
    inst_sram_addr = 32'h0000_1000;
    repeat (n) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
      chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
      chk("rst_rready", {31'd0, rready}, 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0; inst_sram_req = 1'b0;
    clear_model();
    @(negedge clk);
    chk("rst_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
    chk("rst_rdata", inst_sram_rdata, 32'd0);
    chk("rst_perf_req", perf_req_cnt, 32'd0);
    chk("rst_perf_wait", perf_wait_cnt, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'b10; inst_sram_wstrb = 4'hf;
    inst_sram_addr = 0; inst_sram_wdata = 0; i_cached_or_not = 0;
    arready = 0; rid = 4'd0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    clear_model();

    do_reset(3);
    chk("arlen", {24'd0, arlen}, 32'd0);
    chk("arsize", {29'd0, arsize}, 32'd2);
    chk("arburst", {30'd0, arburst}, 32'd1);
    chk("arid", {28'd0, arid}, 32'd0);

    // stray R beat with nothing outstanding must not be accepted
    @(posedge clk); #1;
    rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
    @(negedge clk);
    chk("stray_rready", {31'd0, rready}, 32'd0);
    @(posedge clk); #1;
    rvalid = 1'b0;

    // minimum-latency single fetch from the reset vector
    ar_prob = 100; r_dmin = 1; r_dmax = 1; lat_chk = 1;
    issue(32'h1fc0_0000, 1'b0);
    drain();
    issue(32'h0000_0040, 1'b1);
    drain();
    lat_chk = 0;

    // three requests with a 2-cycle R delay, then perf snapshot
    r_dmin = 2; r_dmax = 2;
    issue(32'h0000_0100, 1'b1);
    issue(32'h0000_0104, 1'b1);
    issue(32'h0000_0108, 1'b0);
    drain();
    check_perf("perf3");
`ifdef INST_BRIDGE_PERF_EN
    chk("perf3_req_lit", perf_req_cnt, 32'd5);
`endif

    // error response
    r_dmin = 1; r_dmax = 1;
    issue(32'he000_0000, 1'b0);
    drain();

    // AR back-pressure: address held, no second accept, third blocked at MAX
    ar_prob = 0;
    step(1'b1, 32'h0000_2000, 1'b1);
    repeat (4) step(1'b1, 32'h0000_2004, 1'b0);
    ar_prob = 100; r_dmin = 6; r_dmax = 6;
    issue(32'h0000_2004, 1'b0);
    issue(32'h0000_2008, 1'b1);
    drain();

    // randomized traffic
    ar_prob = 60; r_dmin = 1; r_dmax = 4;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = {$urandom} & 32'hffff_fffc;
      step($urandom_range(99) < 70, a, 1'($urandom));
    end
    ar_prob = 100; r_dmin = 1; r_dmax = 1;
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = {$urandom} & 32'hffff_fffc;
      step(1'b1, a, 1'($urandom));
    end
    drain();
    check_perf("perf_end");

    // reset with reads in flight drops everything
    r_dmin = 5; r_dmax = 5;
    issue(32'h0000_3000, 1'b0);
    issue(32'h0000_3004, 1'b0);
    step(1'b0, 32'd0, 1'b0);
    do_reset(2);
    repeat (8) step(1'b0, 32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
